alarm_clock_ctrl: RTL and testbench

Time-keeping and mode controller for the alarm clock. Maintains the running 24-hour clock and the alarm setting as BCD digits, sequences set-time / set-alarm / run modes from user buttons, and raises the buzzer on alarm match. Its digit outputs and `show_alarm` drive the 7-segment display decoder directly: `c_*` to clock digits, `a_*` to alarm digits, `show_alarm` to its `alarm` select.

---
 rtl/alarm_clock_pkg.sv | 40 ++++
 rtl/bcd_time_counter.sv | 50 +++++
 rtl/alarm_clock_ctrl.sv | 158 +++++++++++++++
 tb/tb_alarm_clock_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_pkg.sv
// Shared types and BCD helpers for the alarm clock controller.
package alarm_clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_SET_TIME  = 2'd1,
        ST_SET_ALARM = 2'd2
    } state_e;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t hr2;
        bcd_t hr1;
        bcd_t min2;
        bcd_t min1;
    } hhmm_t;

    localparam bcd_t MIN_TENS_MAX   = 4'd5;
    localparam int   HR_MAX         = 23;
    localparam bcd_t HR_TENS_MAX    = bcd_t'(HR_MAX / 10);
    localparam bcd_t HR_ONES_AT_MAX = bcd_t'(HR_MAX % 10);

    // Adds a whole number of minutes modulo 24h; used for multi-minute jumps only.
    function automatic hhmm_t add_minutes(hhmm_t t, int m);
        int    total;
        int    hr;
        int    mn;
        hhmm_t r;
        total = ((int'(t.hr2) * 10 + int'(t.hr1)) * 60 + int'(t.min2) * 10 + int'(t.min1) + m) % (24 * 60);
        hr    = total / 60;
        mn    = total % 60;
        r.hr2  = bcd_t'(hr / 10);
        r.hr1  = bcd_t'(hr % 10);
        r.min2 = bcd_t'(mn / 10);
        r.min1 = bcd_t'(mn % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// hh:mm BCD register: tick_min carries into hours, inc_min/inc_hr wrap independently.
module bcd_time_counter
    import alarm_clock_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  tick_min,
    input  logic  inc_min,
    input  logic  inc_hr,
    output hhmm_t value
);

    logic min_wrap;
    logic hr_wrap;
    logic min_step;
    logic hr_step;

    assign min_wrap = (value.min2 == MIN_TENS_MAX) && (value.min1 == 4'd9);
    assign hr_wrap  = (value.hr2 == HR_TENS_MAX) && (value.hr1 == HR_ONES_AT_MAX);
    assign min_step = tick_min | inc_min;
    // Only the running tick carries; a manual minute bump never touches hours.
    assign hr_step  = inc_hr | (tick_min & min_wrap);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else begin
            if (min_step) begin
                if (value.min1 == 4'd9) begin
                    value.min1 <= 4'd0;
                    value.min2 <= min_wrap ? 4'd0 : value.min2 + 4'd1;
                end else begin
                    value.min1 <= value.min1 + 4'd1;
                end
            end
            if (hr_step) begin
                if (hr_wrap) begin
                    value.hr2 <= 4'd0;
                    value.hr1 <= 4'd0;
                end else if (value.hr1 == 4'd9) begin
                    value.hr1 <= 4'd0;
                    value.hr2 <= value.hr2 + 4'd1;
                end else begin
                    value.hr1 <= value.hr1 + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock: 24h BCD clock, alarm setting, set-mode sequencing and buzzer.
// Snooze support is compiled in when ALARM_SNOOZE_EN is defined.
module alarm_clock_ctrl
    import alarm_clock_pkg::*;
#(
    parameter int SEC_PER_MIN = 60,
    parameter int BUZZ_MIN    = 1
`ifdef ALARM_SNOOZE_EN
    ,
    parameter int SNOOZE_MIN  = 9
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       set_time,
    input  logic       set_alarm,
    input  logic       inc_hr,
    input  logic       inc_min,
    input  logic       alarm_en,
`ifdef ALARM_SNOOZE_EN
    input  logic       snooze,
`endif
    output logic [3:0] c_min1,
    output logic [3:0] c_min2,
    output logic [3:0] c_hr1,
    output logic [3:0] c_hr2,
    output logic [3:0] a_min1,
    output logic [3:0] a_min2,
    output logic [3:0] a_hr1,
    output logic [3:0] a_hr2,
    output logic       show_alarm,
    output logic       buzz
);

    localparam logic [1:0] S_RUN       = ST_RUN;
    localparam logic [1:0] S_SET_TIME  = ST_SET_TIME;
    localparam logic [1:0] S_SET_ALARM = ST_SET_ALARM;

    localparam int              SEC_W    = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_PER_MIN - 1);
    localparam int              BZ_W     = (BUZZ_MIN > 1) ? $clog2(BUZZ_MIN) : 1;
    localparam logic [BZ_W-1:0]  BZ_LAST  = BZ_W'(BUZZ_MIN - 1);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [SEC_W-1:0] sec_cnt;
    logic [BZ_W-1:0]  buzz_cnt;
    logic             rollover;
    logic             rolled;
    logic             enter_set;
    logic             alarm_hit;
    logic             snz_take;
    logic             snz_hit;
    hhmm_t            clk_time;
    hhmm_t            alm_time;

    always_comb begin
        state_nx = state;
        case (state)
            S_RUN:       if (set_time) state_nx = S_SET_TIME;
                         else if (set_alarm) state_nx = S_SET_ALARM;
            S_SET_TIME:  if (!set_time) state_nx = S_RUN;
            S_SET_ALARM: if (!set_alarm) state_nx = S_RUN;
            default:     state_nx = S_RUN;
        endcase
    end

    // Clock runs in RUN and SET_ALARM; only SET_TIME freezes it.
    assign rollover  = (state != S_SET_TIME) && sec_tick && (sec_cnt == SEC_LAST);
    assign enter_set = (state == S_RUN) && (state_nx != S_RUN);
    assign alarm_hit = rolled && (state == S_RUN) && (clk_time == alm_time);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_RUN;
            show_alarm <= 1'b0;
            sec_cnt    <= '0;
            rolled     <= 1'b0;
        end else begin
            state      <= state_nx;
            show_alarm <= (state_nx == S_SET_ALARM);
            rolled     <= rollover && (state == S_RUN);
            if (state == S_SET_TIME)
                sec_cnt <= '0;
            else if (sec_tick)
                sec_cnt <= (sec_cnt == SEC_LAST) ? '0 : sec_cnt + 1'b1;
        end
    end

    bcd_time_counter u_clock (
        .clk      (clk),
        .reset    (reset),
        .tick_min (rollover),
        .inc_min  (inc_min && (state == S_SET_TIME)),
        .inc_hr   (inc_hr && (state == S_SET_TIME)),
        .value    (clk_time)
    );

    bcd_time_counter u_alarm (
        .clk      (clk),
        .reset    (reset),
        .tick_min (1'b0),
        .inc_min  (inc_min && (state == S_SET_ALARM)),
        .inc_hr   (inc_hr && (state == S_SET_ALARM)),
        .value    (alm_time)
    );

`ifdef ALARM_SNOOZE_EN
    hhmm_t snz_time;
    logic  snz_vld;

    assign snz_take = snooze && buzz;
    assign snz_hit  = rolled && (state == S_RUN) && snz_vld && (clk_time == snz_time);

    always_ff @(posedge clk) begin
        if (reset) begin
            snz_vld  <= 1'b0;
            snz_time <= '0;
        end else if (!alarm_en || enter_set) begin
            snz_vld <= 1'b0;
        end else if (snz_take) begin
            snz_vld  <= 1'b1;
            snz_time <= add_minutes(clk_time, SNOOZE_MIN);
        end else if (snz_hit) begin
            snz_vld <= 1'b0;
        end
    end
`else
    assign snz_take = 1'b0;
    assign snz_hit  = 1'b0;
`endif

    // Match is taken one cycle after the rollover so it sees the updated clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            buzz     <= 1'b0;
            buzz_cnt <= '0;
        end else if (!alarm_en || enter_set || snz_take) begin
            buzz     <= 1'b0;
            buzz_cnt <= '0;
        end else if (alarm_hit || snz_hit) begin
            buzz     <= 1'b1;
            buzz_cnt <= '0;
        end else if (rolled && buzz) begin
            if (buzz_cnt == BZ_LAST) begin
                buzz     <= 1'b0;
                buzz_cnt <= '0;
            end else begin
                buzz_cnt <= buzz_cnt + 1'b1;
            end
        end
    end

    assign {c_hr2, c_hr1, c_min2, c_min1} = clk_time;
    assign {a_hr2, a_hr1, a_min2, a_min1} = alm_time;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Self-checking bench for alarm_clock_ctrl: directed scenarios plus a random run
// against a minutes-of-day reference model.
module tb_alarm_clock_ctrl;

    localparam int SPM = 2;
    localparam int BZM = 1;
    localparam int SNZ = 9;

    logic clk = 1'b0;
    logic reset, sec_tick, set_time, set_alarm, inc_hr, inc_min, alarm_en;
`ifdef ALARM_SNOOZE_EN
    logic snooze;
`endif
    logic snz_in;
    logic [3:0] c_min1, c_min2, c_hr1, c_hr2, a_min1, a_min2, a_hr1, a_hr2;
    logic show_alarm, buzz;
    logic [15:0] c_all, a_all;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alarm_clock_ctrl #(.SEC_PER_MIN(SPM), .BUZZ_MIN(BZM)) dut (
        .clk        (clk),
        .reset      (reset),
        .sec_tick   (sec_tick),
        .set_time   (set_time),
        .set_alarm  (set_alarm),
        .inc_hr     (inc_hr),
        .inc_min    (inc_min),
        .alarm_en   (alarm_en),
`ifdef ALARM_SNOOZE_EN
        .snooze     (snooze),
`endif
        .c_min1     (c_min1),
        .c_min2     (c_min2),
        .c_hr1      (c_hr1),
        .c_hr2      (c_hr2),
        .a_min1     (a_min1),
        .a_min2     (a_min2),
        .a_hr1      (a_hr1),
        .a_hr2      (a_hr2),
        .show_alarm (show_alarm),
        .buzz       (buzz)
    );

    assign c_all = {c_hr2, c_hr1, c_min2, c_min1};
    assign a_all = {a_hr2, a_hr1, a_min2, a_min1};
`ifdef ALARM_SNOOZE_EN
    assign snz_in = snooze;
`else
    assign snz_in = 1'b0;
`endif

    // Reference model: times kept as minutes of the day, modes as small integers.
    typedef struct {
        int clk_m;
        int alm_m;
        int sec;
        int mode;   // 0 run, 1 set time, 2 set alarm
        int bcnt;
        int snz_m;
        bit buzz;
        bit pend;   // a running minute rollover in RUN happened last cycle
        bit snz_v;
    } model_t;

    model_t m = '{default: 0};

    function automatic model_t step(model_t s, bit rst, bit tk, bit st, bit sa,
                                    bit ih, bit im, bit en, bit snz);
        model_t n;
        int h, mi, base;
        bit roll, enter, snz_match;
        n = s;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        enter = (s.mode == 0) && (st || sa);
        case (s.mode)
            0:       n.mode = st ? 1 : (sa ? 2 : 0);
            1:       n.mode = st ? 1 : 0;
            default: n.mode = sa ? 2 : 0;
        endcase
        roll = 1'b0;
        if (s.mode == 1) begin
            n.sec = 0;
        end else if (tk) begin
            if (s.sec == SPM - 1) begin
                n.sec   = 0;
                roll    = 1'b1;
                n.clk_m = (s.clk_m + 1) % 1440;
            end else begin
                n.sec = s.sec + 1;
            end
        end
        if (s.mode != 0) begin
            base = (s.mode == 1) ? s.clk_m : s.alm_m;
            h  = base / 60;
            mi = base % 60;
            if (im) mi = (mi + 1) % 60;
            if (ih) h = (h + 1) % 24;
            if (s.mode == 1) n.clk_m = h * 60 + mi;
            else             n.alm_m = h * 60 + mi;
        end
        n.pend = roll && (s.mode == 0);
        snz_match = s.snz_v && (s.clk_m == s.snz_m);
        if (!en || enter) begin
            n.buzz = 0; n.bcnt = 0; n.snz_v = 0;
        end else if (snz && s.buzz) begin
            n.buzz = 0; n.bcnt = 0; n.snz_v = 1;
            n.snz_m = (s.clk_m + SNZ) % 1440;
        end else if (s.pend && s.mode == 0 && (s.clk_m == s.alm_m || snz_match)) begin
            n.buzz = 1; n.bcnt = 0;
            if (snz_match) n.snz_v = 0;
        end else if (s.pend && s.buzz) begin
            n.bcnt = s.bcnt + 1;
            if (n.bcnt == BZM) begin
                n.buzz = 0; n.bcnt = 0;
            end
        end
        return n;
    endfunction

    function automatic logic [15:0] to_bcd(int t);
        int h, mi;
        h  = t / 60;
        mi = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10)};
    endfunction

    always @(posedge clk)
        m <= step(m, reset, sec_tick, set_time, set_alarm, inc_hr, inc_min, alarm_en, snz_in);

    task automatic cyc(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic sec_pulse();
        sec_tick = 1'b1; cyc(); sec_tick = 1'b0;
    endtask

    task automatic press_min(int n);
        repeat (n) begin inc_min = 1'b1; cyc(); inc_min = 1'b0; end
    endtask

    task automatic press_hr(int n);
        repeat (n) begin inc_hr = 1'b1; cyc(); inc_hr = 1'b0; end
    endtask

    task automatic test_reset();
        reset = 1'b1; cyc(2); reset = 1'b0;
        checks++; if (c_all !== 16'h0000) begin errors++; $display("FAIL reset_clock: got %h want 0000", c_all); end
        checks++; if (a_all !== 16'h0000) begin errors++; $display("FAIL reset_alarm: got %h want 0000", a_all); end
        checks++; if (buzz !== 1'b0) begin errors++; $display("FAIL reset_buzz: got %b want 0", buzz); end
        checks++; if (show_alarm !== 1'b0) begin errors++; $display("FAIL reset_show: got %b want 0", show_alarm); end
        repeat (4) sec_pulse();
        checks++; if (c_all !== 16'h0002) begin errors++; $display("FAIL run_4_ticks: got %h want 0002", c_all); end
        checks++; if (buzz !== 1'b0 || show_alarm !== 1'b0) begin
            errors++; $display("FAIL run_outputs: got buzz=%b show=%b want 0 0", buzz, show_alarm);
        end
        // Bring the clock back to 00:00 for the following scenarios.
        reset = 1'b1; cyc(); reset = 1'b0;
    endtask

    task automatic test_set_time();
        set_time = 1'b1; cyc();
        checks++; if (show_alarm !== 1'b0) begin errors++; $display("FAIL set_time_show: got %b want 0", show_alarm); end
        press_hr(23); press_min(59);
        checks++; if (c_all !== 16'h2359) begin errors++; $display("FAIL set_time_load: got %h want 2359", c_all); end
        sec_pulse(); sec_pulse();
        checks++; if (c_all !== 16'h2359) begin errors++; $display("FAIL set_time_frozen: got %h want 2359", c_all); end
        press_min(1);
        checks++; if (c_all !== 16'h2300) begin errors++; $display("FAIL set_time_min_wrap: got %h want 2300", c_all); end
        press_min(59);
        set_time = 1'b0; cyc();
        sec_pulse();
        checks++; if (c_all !== 16'h2359) begin errors++; $display("FAIL run_first_tick: got %h want 2359", c_all); end
        sec_pulse();
        checks++; if (c_all !== 16'h0000) begin errors++; $display("FAIL run_day_wrap: got %h want 0000", c_all); end
    endtask

    task automatic test_alarm();
        set_alarm = 1'b1; cyc();
        checks++; if (show_alarm !== 1'b1) begin errors++; $display("FAIL set_alarm_show: got %b want 1", show_alarm); end
        press_min(1);
        checks++; if (a_all !== 16'h0001 || c_all !== 16'h0000) begin
            errors++; $display("FAIL set_alarm_load: got a=%h c=%h want a=0001 c=0000", a_all, c_all);
        end
        set_alarm = 1'b0; cyc();
        checks++; if (show_alarm !== 1'b0) begin errors++; $display("FAIL set_alarm_release: got %b want 0", show_alarm); end
        alarm_en = 1'b1;
        sec_pulse(); sec_pulse();
        checks++; if (c_all !== 16'h0001 || buzz !== 1'b0) begin
            errors++; $display("FAIL alarm_pre_buzz: got c=%h buzz=%b want 0001 0", c_all, buzz);
        end
        cyc();
        checks++; if (buzz !== 1'b1) begin errors++; $display("FAIL alarm_buzz: got %b want 1", buzz); end
        sec_pulse(); sec_pulse();
        checks++; if (buzz !== 1'b1) begin errors++; $display("FAIL alarm_buzz_hold: got %b want 1", buzz); end
        cyc();
        checks++; if (buzz !== 1'b0) begin errors++; $display("FAIL alarm_auto_clear: got %b want 0", buzz); end
    endtask

    task automatic test_alarm_en_drop();
        set_alarm = 1'b1; cyc(); press_min(2); set_alarm = 1'b0; cyc();
        checks++; if (a_all !== 16'h0003) begin errors++; $display("FAIL alarm_reload: got %h want 0003", a_all); end
        sec_pulse(); sec_pulse(); cyc();
        checks++; if (buzz !== 1'b1) begin errors++; $display("FAIL en_drop_buzz: got %b want 1", buzz); end
        alarm_en = 1'b0; cyc();
        checks++; if (buzz !== 1'b0) begin errors++; $display("FAIL en_drop_clear: got %b want 0", buzz); end
        alarm_en = 1'b1;
        set_time = 1'b1; cyc(); press_min(1); press_min(59);
        checks++; if (c_all !== 16'h0003) begin errors++; $display("FAIL set_equal_time: got %h want 0003", c_all); end
        set_time = 1'b0; cyc(3);
        checks++; if (buzz !== 1'b0) begin errors++; $display("FAIL set_equal_no_buzz: got %b want 0", buzz); end
    endtask

    task automatic test_priority_and_reset();
        set_time = 1'b1; set_alarm = 1'b1; cyc();
        checks++; if (show_alarm !== 1'b0) begin errors++; $display("FAIL priority_show: got %b want 0", show_alarm); end
        press_min(1);
        checks++; if (c_all !== 16'h0004 || a_all !== 16'h0003) begin
            errors++; $display("FAIL priority_target: got c=%h a=%h want c=0004 a=0003", c_all, a_all);
        end
        set_time = 1'b0; set_alarm = 1'b0; cyc();
        set_alarm = 1'b1; cyc(); press_min(2); set_alarm = 1'b0; cyc();
        sec_pulse(); sec_pulse(); cyc();
        checks++; if (buzz !== 1'b1) begin errors++; $display("FAIL pre_reset_buzz: got %b want 1", buzz); end
        reset = 1'b1; cyc(); reset = 1'b0;
        checks++; if ({c_all, a_all, show_alarm, buzz} !== 34'd0) begin
            errors++; $display("FAIL reset_mid_buzz: got c=%h a=%h show=%b buzz=%b want all 0", c_all, a_all, show_alarm, buzz);
        end
    endtask

`ifdef ALARM_SNOOZE_EN
    task automatic test_snooze();
        set_alarm = 1'b1; cyc(); press_hr(6); press_min(30); set_alarm = 1'b0; cyc();
        set_time = 1'b1; cyc(); press_hr(6); press_min(29); set_time = 1'b0; cyc();
        checks++; if (c_all !== 16'h0629 || a_all !== 16'h0630) begin
            errors++; $display("FAIL snooze_setup: got c=%h a=%h want 0629 0630", c_all, a_all);
        end
        sec_pulse(); sec_pulse(); cyc();
        checks++; if (buzz !== 1'b1) begin errors++; $display("FAIL snooze_first_buzz: got %b want 1", buzz); end
        snooze = 1'b1; cyc(); snooze = 1'b0;
        checks++; if (buzz !== 1'b0) begin errors++; $display("FAIL snooze_clear: got %b want 0", buzz); end
        repeat (8) begin sec_pulse(); sec_pulse(); end
        cyc();
        checks++; if (c_all !== 16'h0638 || buzz !== 1'b0) begin
            errors++; $display("FAIL snooze_wait: got c=%h buzz=%b want 0638 0", c_all, buzz);
        end
        sec_pulse(); sec_pulse(); cyc();
        checks++; if (c_all !== 16'h0639 || buzz !== 1'b1) begin
            errors++; $display("FAIL snooze_rebuzz: got c=%h buzz=%b want 0639 1", c_all, buzz);
        end
    endtask
`endif

    task automatic test_random();
        logic [33:0] got, want;
        reset = 1'b1; cyc(); reset = 1'b0;
        set_alarm = 1'b1; cyc(); press_min(5); set_alarm = 1'b0; cyc();
        alarm_en = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            sec_tick = ($urandom_range(9) < 6);
            inc_hr   = ($urandom_range(9) < 2);
            inc_min  = ($urandom_range(9) < 3);
            if ($urandom_range(99) < 2) set_time = ~set_time;
            if ($urandom_range(99) < 2) set_alarm = ~set_alarm;
            if ($urandom_range(199) < 1) alarm_en = ~alarm_en;
            reset = ($urandom_range(999) < 2);
`ifdef ALARM_SNOOZE_EN
            snooze = ($urandom_range(9) < 1);
`endif
            cyc();
            got  = {c_all, a_all, show_alarm, buzz};
            want = {to_bcd(m.clk_m), to_bcd(m.alm_m), m.mode == 2, m.buzz};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL random cyc %0d: got c=%h a=%h show=%b buzz=%b want c=%h a=%h show=%b buzz=%b",
                         i, got[33:18], got[17:2], got[1], got[0], want[33:18], want[17:2], want[1], want[0]);
            end
        end
        {sec_tick, inc_hr, inc_min, set_time, set_alarm, reset} = '0;
    endtask

    initial begin
        reset = 1'b1; sec_tick = 1'b0; set_time = 1'b0; set_alarm = 1'b0;
        inc_hr = 1'b0; inc_min = 1'b0; alarm_en = 1'b0;
`ifdef ALARM_SNOOZE_EN
        snooze = 1'b0;
`endif
        test_reset();
        test_set_time();
        test_alarm();
        test_alarm_en_drop();
        test_priority_and_reset();
`ifdef ALARM_SNOOZE_EN
        test_snooze();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
